// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory address/data, decode handshake and control.
interface instruction_fetch_unit_if;
  logic        start;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        halted;

  // fetch unit side
  modport master (
    input  start, redirect_valid, redirect_pc, instruction, out_ready,
    output pc, out_valid, out_instr, out_pc, halted
  );

  // environment side: memory, decode and control
  modport slave (
    output start, redirect_valid, redirect_pc, instruction, out_ready,
    input  pc, out_valid, out_instr, out_pc, halted
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, captures combinational memory read
// data into a fetch register and hands it to decode via valid/ready.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] PC_STEP     = 16'd1,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input logic                       clk,
  input logic                       rst_n,
  instruction_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

  state_t      state;
  logic [15:0] pc;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        halted;
  logic        cap;
  logic        is_halt;

  // Capture only when the fetch register is free or being drained this cycle.
  assign cap     = (state == FETCH) && !bus.redirect_valid && (!out_valid || bus.out_ready);
  assign is_halt = (bus.instruction[15:12] == HALT_OPCODE);

  assign bus.pc        = pc;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = out_instr;
  assign bus.out_pc    = out_pc;
  assign bus.halted    = halted;

  // Control FSM, PC and fetch register; redirect outranks start and capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= 16'h0000;
      out_pc    <= 16'h0000;
      halted    <= 1'b0;
    end else begin
      // default drain: accepted instruction leaves unless replaced below
      if (out_valid && bus.out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.redirect_valid) pc <= bus.redirect_pc;
          if (bus.start) state <= FETCH;
        end
        FETCH: begin
          if (bus.redirect_valid) begin
            pc        <= bus.redirect_pc;
            out_valid <= 1'b0;
          end else if (cap) begin
            out_instr <= bus.instruction;
            out_pc    <= pc;
            out_valid <= 1'b1;
            if (is_halt) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              pc <= pc + PC_STEP;
            end
          end
        end
        HALTED: begin
          if (bus.redirect_valid) begin
            pc        <= bus.redirect_pc;
            out_valid <= 1'b0;
            state     <= FETCH;
            halted    <= 1'b0;
          end else if (bus.start) begin
            // resume past the halt word
            pc     <= pc + PC_STEP;
            state  <= FETCH;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a small behavioural ROM.
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] mem [0:255];

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC(16'h0000), .PC_STEP(16'd1), .HALT_OPCODE(4'hF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // asynchronous ROM, aliased on the low address byte
  assign bus.instruction = mem[bus.pc[7:0]];

  // inputs change and outputs are sampled at the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 16'h0; bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 16'h0; bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", bus.pc); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_instr !== 16'h0000 || bus.out_pc !== 16'h0000) begin errors++; $display("FAIL reset_outregs got %h/%h want 0000/0000", bus.out_instr, bus.out_pc); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", bus.halted); end
    rst_n = 1'b1;
    // start streaming, then pull reset mid-fetch away from any edge
    bus.start = 1'b1; step(); bus.start = 1'b0; step(); step();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midop_valid got %b want 1", bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.pc !== 16'h0000 || bus.out_valid !== 1'b0 || bus.halted !== 1'b0) begin errors++; $display("FAIL async_reset got pc=%h v=%b h=%b want 0000/0/0", bus.pc, bus.out_valid, bus.halted); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++; if (bus.out_valid !== 1'b0 || bus.pc !== 16'h0000) begin errors++; $display("FAIL idle_quiet got v=%b pc=%h want 0/0000", bus.out_valid, bus.pc); end
  endtask

  task automatic test_streaming();
    logic [15:0] exp [0:3];
    exp[0] = 16'h1111; exp[1] = 16'h2222; exp[2] = 16'h3333; exp[3] = 16'h4444;
    do_reset();
    bus.out_ready = 1'b1; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_first_edge got %b want 0", bus.out_valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== exp[i] || bus.out_pc !== 16'(i)) begin
        errors++; $display("FAIL stream_%0d got v=%b instr=%h pc=%h want 1/%h/%h", i, bus.out_valid, bus.out_instr, bus.out_pc, exp[i], 16'(i));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready = 1'b1; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    step(); step();   // 2222 now held
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== 16'h2222 || bus.out_pc !== 16'h0001 || bus.pc !== 16'h0002) begin
        errors++; $display("FAIL stall_%0d got v=%b instr=%h opc=%h pc=%h want 1/2222/0001/0002", i, bus.out_valid, bus.out_instr, bus.out_pc, bus.pc);
      end
    end
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_instr !== 16'h3333 || bus.out_pc !== 16'h0002 || bus.pc !== 16'h0003) begin errors++; $display("FAIL stall_release got instr=%h opc=%h pc=%h want 3333/0002/0003", bus.out_instr, bus.out_pc, bus.pc); end
    step();
    checks++; if (bus.out_instr !== 16'h4444 || bus.out_pc !== 16'h0003) begin errors++; $display("FAIL stall_next got instr=%h opc=%h want 4444/0003", bus.out_instr, bus.out_pc); end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.out_ready = 1'b1; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0040;
    step(); bus.redirect_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.pc !== 16'h0040) begin errors++; $display("FAIL redir_flush got v=%b pc=%h want 0/0040", bus.out_valid, bus.pc); end
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0040 || bus.out_instr !== 16'h4040) begin errors++; $display("FAIL redir_target got v=%b opc=%h instr=%h want 1/0040/4040", bus.out_valid, bus.out_pc, bus.out_instr); end
    // redirect together with start from IDLE
    do_reset();
    bus.out_ready = 1'b1; bus.start = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0040;
    step(); bus.start = 1'b0; bus.redirect_valid = 1'b0;
    checks++; if (bus.pc !== 16'h0040 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_redir_pc got pc=%h v=%b want 0040/0", bus.pc, bus.out_valid); end
    step();
    checks++; if (bus.out_pc !== 16'h0040 || bus.out_instr !== 16'h4040 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL idle_redir_cap got opc=%h instr=%h v=%b want 0040/4040/1", bus.out_pc, bus.out_instr, bus.out_valid); end
  endtask

  task automatic test_halt();
    do_reset();
    bus.out_ready = 1'b1; bus.start = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0004;
    step(); bus.start = 1'b0; bus.redirect_valid = 1'b0;
    step();   // 5555 @4
    step();   // F000 @5
    checks++; if (bus.out_instr !== 16'hF000 || bus.out_pc !== 16'h0005 || bus.halted !== 1'b1 || bus.pc !== 16'h0005 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL halt_cap got instr=%h opc=%h h=%b pc=%h v=%b want F000/0005/1/0005/1", bus.out_instr, bus.out_pc, bus.halted, bus.pc, bus.out_valid); end
    bus.out_ready = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.halted !== 1'b1 || bus.pc !== 16'h0005) begin errors++; $display("FAIL halt_hold got v=%b h=%b pc=%h want 1/1/0005", bus.out_valid, bus.halted, bus.pc); end
    bus.out_ready = 1'b1;
    step(); step();
    checks++; if (bus.out_valid !== 1'b0 || bus.halted !== 1'b1 || bus.pc !== 16'h0005) begin errors++; $display("FAIL halt_drain got v=%b h=%b pc=%h want 0/1/0005", bus.out_valid, bus.halted, bus.pc); end
    bus.start = 1'b1;
    step(); bus.start = 1'b0;
    checks++; if (bus.pc !== 16'h0006 || bus.halted !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL resume_pc got pc=%h h=%b v=%b want 0006/0/0", bus.pc, bus.halted, bus.out_valid); end
    step();
    checks++; if (bus.out_pc !== 16'h0006 || bus.out_instr !== 16'h6666 || bus.pc !== 16'h0007) begin errors++; $display("FAIL resume_cap got opc=%h instr=%h pc=%h want 0006/6666/0007", bus.out_pc, bus.out_instr, bus.pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.out_ready = 1'b1; bus.start = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 16'hFFFF;
    step(); bus.start = 1'b0; bus.redirect_valid = 1'b0;
    step();
    checks++; if (bus.out_pc !== 16'hFFFF || bus.out_instr !== 16'hABCD || bus.pc !== 16'h0000) begin errors++; $display("FAIL wrap_cap got opc=%h instr=%h pc=%h want FFFF/ABCD/0000", bus.out_pc, bus.out_instr, bus.pc); end
    step();
    checks++; if (bus.out_pc !== 16'h0000 || bus.out_instr !== 16'h1111) begin errors++; $display("FAIL wrap_next got opc=%h instr=%h want 0000/1111", bus.out_pc, bus.out_instr); end
    // redirect beats start while halted
    do_reset();
    bus.out_ready = 1'b1; bus.start = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0005;
    step(); bus.start = 1'b0; bus.redirect_valid = 1'b0;
    step();
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_enter got %b want 1", bus.halted); end
    bus.start = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0040;
    step(); bus.start = 1'b0; bus.redirect_valid = 1'b0;
    checks++; if (bus.pc !== 16'h0040 || bus.halted !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL halt_redir got pc=%h h=%b v=%b want 0040/0/0", bus.pc, bus.halted, bus.out_valid); end
    step();
    checks++; if (bus.out_pc !== 16'h0040 || bus.out_instr !== 16'h4040) begin errors++; $display("FAIL halt_redir_cap got opc=%h instr=%h want 0040/4040", bus.out_pc, bus.out_instr); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[4] = 16'h5555; mem[5] = 16'hF000; mem[6] = 16'h6666; mem[7] = 16'h7777;
    mem[8'h40] = 16'h4040; mem[8'h41] = 16'h4141; mem[8'hFF] = 16'hABCD;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name:
instruction_fetch_unit

Overview:
- Sequences the asynchronous-read InstructionMemory (PC in, Instruction out) for the 16-bit CPU.
- Owns the program counter and drives it onto the memory address.
- Captures the returned word into a fetch register and presents it to decode with a valid/ready handshake.
- Handles start, backpressure stalls, branch/jump redirects and a HALT opcode.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_STEP, 16'd1, PC increment per fetched instruction.
- HALT_OPCODE, 4'hF, value of Instruction[15:12] that stops fetching.

Ports:
- Clock  input  1  single clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse; begins fetching from IDLE or resumes from HALTED.
- RedirectValid  input  1  branch/jump taken; loads RedirectPC and flushes the fetch register.
- RedirectPC  input  16  redirect target address.
- PC  output  16  current fetch address, wired to InstructionMemory PC.
- Instruction  input  16  combinational read data from InstructionMemory.
- OutValid  output  1  OutInstr/OutPC hold a fetched instruction.
- OutReady  input  1  decode accepts the instruction this cycle.
- OutInstr  output  16  fetched instruction word.
- OutPC  output  16  address OutInstr was fetched from.
- Halted  output  1  high while in HALTED.

Behaviour:
- Reset (async, Reset_n=0): State=IDLE, PC=RESET_PC, OutValid=0, OutInstr=0, OutPC=0, Halted=0. Reset takes effect immediately, including mid-fetch or mid-stall. A pending instruction is dropped.
- The PC output is the PC register itself; memory read is combinational, so Instruction is valid in the same cycle.
- Capture condition: Cap = (State==FETCH) && !RedirectValid && (!OutValid || OutReady).
- When Cap is true, at the rising edge:
  - OutInstr<=Instruction, OutPC<=PC, OutValid<=1.
  - If Instruction[15:12] != HALT_OPCODE: PC<=PC+PC_STEP, modulo 2^16 (16'hFFFF+1 wraps to 16'h0000).
  - If Instruction[15:12] == HALT_OPCODE: PC is held and State<=HALTED.
- Handshake:
  - If OutValid && OutReady && !Cap: OutValid<=0.
  - If OutValid && !OutReady: OutInstr, OutPC, OutValid and PC all hold (stall).
  - Throughput is one instruction per cycle while OutReady=1.
- States:
  - IDLE: no capture.
    - Start -> FETCH; the first capture happens at the end of the following cycle, so OutValid rises 2 edges after Start is sampled.
    - RedirectValid loads PC<=RedirectPC; this sets the start address. Start together with Redirect -> FETCH at the target.
  - FETCH: capture per the rules above. RedirectValid -> PC<=RedirectPC, OutValid<=0, no capture that cycle, stay in FETCH. The next capture is the target word, one cycle later.
  - HALTED: Halted=1. The halt instruction stays on OutInstr until accepted, then OutValid<=0.
    - Start -> PC<=PC+PC_STEP, State<=FETCH.
    - RedirectValid -> PC<=RedirectPC, OutValid<=0, State<=FETCH. Redirect wins over Start.
- Priority: Reset_n > RedirectValid > Start > capture/handshake.
- Start while already in FETCH is ignored.
- Halted is registered: it rises on the same edge as the State change.

Test Plan:
- Reset: assert Reset_n=0 mid-operation with OutValid=1 -> immediately PC=0, OutValid=0, Halted=0, State=IDLE; no activity without Start.
- Streaming: memory 0..3 = 16'h1111,16'h2222,16'h3333,16'h4444, OutReady=1, Start pulse -> OutInstr sequence 1111,2222,3333,4444 on consecutive cycles, OutPC 0,1,2,3, first OutValid 2 edges after Start.
- Backpressure: drop OutReady for 3 cycles while OutInstr=16'h2222 -> OutInstr, OutPC=1 and PC=2 all frozen; after OutReady=1, 3333 follows next cycle with no instruction lost or duplicated.
- Redirect: RedirectValid with RedirectPC=16'h0040 while OutValid=1 -> OutValid=0 next cycle, then OutPC=16'h0040 the cycle after; redirect and Start in IDLE start fetch at 16'h0040.
- Halt: word at address 5 = 16'hF000 -> captured with OutPC=5, Halted=1, PC stays 5, OutValid clears after acceptance; Start resumes with the next capture from PC=6.
- Wrap: redirect to 16'hFFFF with non-halt word -> next OutPC=16'h0000; RedirectValid held in HALTED with Start -> redirect target used.
